// File: rtl/nine_segment_scanner.sv
// nine_segment_scanner: 3x3 LED matrix row scanner with a shadow pattern buffer.
// Ports: clk, rst_n (sync, active-low), enable, segments_in[8:0], load,
//   load_ready, rows[2:0] (active-high anodes), cols[2:0] (active-low
//   cathodes), frame_start (pulse on the first row-2 drive cycle).
module nine_segment_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [8:0] segments_in,
    input  logic       load,
    output logic       load_ready,
    output logic [2:0] rows,
    output logic [2:0] cols,
    output logic       frame_start
);

    // One counter serves both the dwell and the blank phases.
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                          DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d, row_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    active_q, active_d;
    logic [8:0]    shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          enter_drive;
    logic          frame_entry;
    logic          accept;
    logic          copy;
    logic [2:0]    rows_d, cols_d;
    logic [2:0]    row_bits;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= 2'd2;
            cnt_q       <= '0;
            active_q    <= 9'h000;
            shadow_q    <= 9'h000;
            pending_q   <= 1'b0;
            rows        <= 3'b000;
            cols        <= 3'b111;
            load_ready  <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            rows        <= rows_d;
            cols        <= cols_d;
            load_ready  <= ~pending_d;
            frame_start <= frame_entry;
        end
    end

    // Next-state logic. Scan order is row 2, 1, 0, then back to 2.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        enter_drive = 1'b0;
        row_nxt     = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;

        if (!enable) begin
            state_d = IDLE;
            row_d   = 2'd2;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = DRIVE;
                    row_d       = 2'd2;
                    cnt_d       = DWELL_LOAD;
                    enter_drive = 1'b1;
                end
                DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (BLANK_CYCLES == 0) begin
                        state_d     = DRIVE;
                        row_d       = row_nxt;
                        cnt_d       = DWELL_LOAD;
                        enter_drive = 1'b1;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d     = DRIVE;
                        row_d       = row_nxt;
                        cnt_d       = DWELL_LOAD;
                        enter_drive = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = 2'd2;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_entry = enter_drive && (row_d == 2'd2);
    end

    // Pattern buffering. The shadow only moves to active at a frame
    // boundary so a frame is never drawn from two different patterns.
    // accept needs pending=0 and copy needs pending=1, so they never
    // fire together.
    always_comb begin
        accept    = load & load_ready;
        copy      = frame_entry & pending_q;
        active_d  = copy ? shadow_q : active_q;
        shadow_d  = accept ? segments_in : shadow_q;
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (copy) begin
            pending_d = 1'b0;
        end
    end

    // Output decode from the next state so rows/cols change on the same
    // edge as the state they belong to.
    always_comb begin
        rows_d = 3'b000;
        cols_d = 3'b111;
        unique case (row_d)
            2'd2:    row_bits = active_d[8:6];
            2'd1:    row_bits = active_d[5:3];
            default: row_bits = active_d[2:0];
        endcase
        if (state_d == DRIVE) begin
            rows_d = 3'b001 << row_d;
            cols_d = ~row_bits;
        end
    end

endmodule
